free_list: RTL and testbench

- Tracks which shared packet-memory blocks are free.
- Sits directly downstream of the port arbiter. It serves one allocation request stream and one free request stream, both already serialised across ports.
- Returns freed block indices in FIFO order.
- Keeps a per-block reference count so a flooded frame's blocks return to the pool only after every egress port has released them.

---
 rtl/free_list_pkg.sv | 23 ++
 rtl/free_list_if.sv | 27 ++
 rtl/free_list_fifo.sv | 54 +++++
 rtl/free_list.sv | 124 ++++++++++++
 tb/tb_free_list.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/free_list_pkg.sv
// Shared constants and types for the packet-memory free list.
package free_list_pkg;

  localparam int unsigned NUM_PORTS  = 4;
  localparam int unsigned ADDR_W     = 4;
  localparam int unsigned BLOCK_BITS = 512;
  localparam int unsigned NUM_BLOCKS = 2 ** ADDR_W;

  // Reference counter width for a switch with n ports: max(1, clog2(n)).
  function automatic int unsigned refcnt_width(input int unsigned n);
    int unsigned w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

  localparam int unsigned REFCNT_W = refcnt_width(NUM_PORTS);

  typedef enum logic {
    FL_INIT,
    FL_RUN
  } fl_state_t;

endpackage

// File: rtl/free_list_if.sv
// Allocation/free request bundle and status between the arbiter and the free list.
interface free_list_if #(
  parameter int unsigned ADDR_W = free_list_pkg::ADDR_W
) ();

  logic              alloc_req_i;
  logic              alloc_gnt_o;
  logic [ADDR_W-1:0] alloc_block_idx_o;
  logic              free_req_i;
  logic [ADDR_W-1:0] free_block_idx_i;
  logic              flood_i;
  logic              ready_o;
  logic              empty_o;
  logic [ADDR_W:0]   free_count_o;
  logic              err_o;

  modport slave (
    input  alloc_req_i, free_req_i, free_block_idx_i, flood_i,
    output alloc_gnt_o, alloc_block_idx_o, ready_o, empty_o, free_count_o, err_o
  );

  modport master (
    output alloc_req_i, free_req_i, free_block_idx_i, flood_i,
    input  alloc_gnt_o, alloc_block_idx_o, ready_o, empty_o, free_count_o, err_o
  );

endinterface

// File: rtl/free_list_fifo.sv
// Circular FIFO of block indices: one push and one pop per cycle, with occupancy count.
module fl_fifo #(
  parameter int unsigned ADDR_W = free_list_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [ADDR_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [ADDR_W-1:0] rd_data_o,
  output logic [ADDR_W:0]   count_o
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the INIT sweep rewrites every entry.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;

endmodule

// File: rtl/free_list.sv
// Shared packet-memory free list: FIFO of free block indices plus per-block flood refcounts.
module free_list
  import free_list_pkg::*;
#(
  parameter int unsigned N      = NUM_PORTS,
  parameter int unsigned ADDR_W = free_list_pkg::ADDR_W
) (
  input  logic        clk,
  input  logic        rst,
  free_list_if.slave  fl
);

  localparam int unsigned NB   = 2 ** ADDR_W;
  localparam int unsigned RC_W = refcnt_width(N);
  localparam bit          SINGLE_READER = (N == 2);
  localparam logic [RC_W-1:0] FLOOD_INIT = RC_W'(N - 2);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NB - 1);
  localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W + 1)'(NB);

  fl_state_t         state_q, state_d;
  logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
  logic              gnt_q, gnt_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              err_q, err_d;
  logic [RC_W-1:0]   refcnt_q [NB];
  logic [RC_W-1:0]   refcnt_d [NB];

  logic              fifo_push;
  logic [ADDR_W-1:0] fifo_push_data;
  logic              fifo_pop;
  logic [ADDR_W-1:0] fifo_rd_data;
  logic [ADDR_W:0]   fifo_count;
  logic              ret;
  logic [ADDR_W-1:0] b;

  fl_fifo #(.ADDR_W(ADDR_W)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (fifo_push),
    .push_data_i (fifo_push_data),
    .pop_i       (fifo_pop),
    .rd_data_o   (fifo_rd_data),
    .count_o     (fifo_count)
  );

  always_comb begin
    state_d        = state_q;
    init_cnt_d     = init_cnt_q;
    gnt_d          = 1'b0;
    idx_d          = idx_q;
    err_d          = err_q;
    refcnt_d       = refcnt_q;
    fifo_push      = 1'b0;
    fifo_push_data = fl.free_block_idx_i;
    fifo_pop       = 1'b0;
    ret            = 1'b0;
    b              = fl.free_block_idx_i;

    case (state_q)
      FL_INIT: begin
        fifo_push           = 1'b1;
        fifo_push_data      = init_cnt_q;
        refcnt_d[init_cnt_q] = '0;
        init_cnt_d          = init_cnt_q + 1'b1;
        if (init_cnt_q == LAST_IDX) state_d = FL_RUN;
        if (fl.alloc_req_i) err_d = 1'b1;
      end

      FL_RUN: begin
        if (fl.alloc_req_i && (fifo_count != '0)) begin
          fifo_pop = 1'b1;
          gnt_d    = 1'b1;
          idx_d    = fifo_rd_data;
        end

        if (fl.free_req_i) begin
          if (!fl.flood_i) begin
            ret = 1'b1;
          end else if (refcnt_q[b] == '0) begin
            // First release of a flooded block arms the count for the remaining readers.
            if (SINGLE_READER) ret = 1'b1;
            else               refcnt_d[b] = FLOOD_INIT;
          end else begin
            refcnt_d[b] = refcnt_q[b] - 1'b1;
            if (refcnt_q[b] == RC_W'(1)) ret = 1'b1;
          end
        end

        if (ret) begin
          if (fifo_count == FULL_CNT) err_d = 1'b1;
          else                        fifo_push = 1'b1;
        end
      end

      default: state_d = FL_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= FL_INIT;
      init_cnt_q <= '0;
      gnt_q      <= 1'b0;
      idx_q      <= '0;
      err_q      <= 1'b0;
      for (int unsigned i = 0; i < NB; i++) refcnt_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      gnt_q      <= gnt_d;
      idx_q      <= idx_d;
      err_q      <= err_d;
      refcnt_q   <= refcnt_d;
    end
  end

  assign fl.alloc_gnt_o       = gnt_q;
  assign fl.alloc_block_idx_o = idx_q;
  assign fl.ready_o           = (state_q == FL_RUN);
  assign fl.free_count_o      = fifo_count;
  assign fl.empty_o           = (fifo_count == '0);
  assign fl.err_o             = err_q;

endmodule

// File: tb/tb_free_list.sv
// Directed bench for free_list: expected grant indices are queued, a negedge monitor checks them.
module tb_free_list;

  localparam int unsigned TB_N  = 4;
  localparam int unsigned TB_AW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  free_list_if #(.ADDR_W(TB_AW)) fl ();

  free_list #(.N(TB_N), .ADDR_W(TB_AW)) dut (
    .clk (clk),
    .rst (rst),
    .fl  (fl)
  );

  int tests = 0;
  int fails = 0;
  int unsigned exp_q[$];

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every grant must match the oldest queued expectation.
  always @(negedge clk) begin
    if (fl.alloc_gnt_o === 1'b1) begin
      if (exp_q.size() == 0) check("grant_expected", exp_q.size(), 1);
      else                   check("grant_idx", fl.alloc_block_idx_o, exp_q.pop_front());
    end
  end

  task automatic free_blk(input int unsigned blk, input logic fld);
    fl.free_req_i       = 1'b1;
    fl.free_block_idx_i = TB_AW'(blk);
    fl.flood_i          = fld;
    @(negedge clk);
    fl.free_req_i = 1'b0;
    fl.flood_i    = 1'b0;
  endtask

  task automatic alloc_n(input int unsigned n);
    fl.alloc_req_i = 1'b1;
    repeat (n) @(negedge clk);
    fl.alloc_req_i = 1'b0;
  endtask

  task automatic wait_ready(output int unsigned cyc);
    cyc = 0;
    while (fl.ready_o !== 1'b1 && cyc < 64) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  int unsigned cyc;

  initial begin
    fl.alloc_req_i      = 1'b0;
    fl.free_req_i       = 1'b0;
    fl.free_block_idx_i = '0;
    fl.flood_i          = 1'b0;
    rst = 1'b1;
    #2;
    check("rst_gnt",   fl.alloc_gnt_o, 0);
    check("rst_idx",   fl.alloc_block_idx_o, 0);
    check("rst_ready", fl.ready_o, 0);
    check("rst_empty", fl.empty_o, 1);
    check("rst_count", fl.free_count_o, 0);
    check("rst_err",   fl.err_o, 0);
    @(negedge clk);
    rst = 1'b0;

    // Initialisation takes exactly NUM_BLOCKS cycles
    wait_ready(cyc);
    check("init_cycles", cyc, 16);
    check("init_count",  fl.free_count_o, 16);
    check("init_empty",  fl.empty_o, 0);
    check("init_err",    fl.err_o, 0);

    // Drain the pool with a held request
    for (int unsigned i = 0; i < 16; i++) exp_q.push_back(i);
    alloc_n(17);
    check("drain_gnt",   fl.alloc_gnt_o, 0);
    check("drain_empty", fl.empty_o, 1);
    check("drain_count", fl.free_count_o, 0);

    // Plain free into an empty pool, then reallocate it
    free_blk(7, 1'b0);
    check("free7_count", fl.free_count_o, 1);
    exp_q.push_back(7);
    alloc_n(1);
    check("realloc7_count", fl.free_count_o, 0);

    // Flood release needs N-1 = 3 frees before the block returns
    free_blk(5, 1'b0);
    check("free5_count", fl.free_count_o, 1);
    free_blk(3, 1'b1);
    check("flood1_count", fl.free_count_o, 1);
    free_blk(3, 1'b1);
    check("flood2_count", fl.free_count_o, 1);
    free_blk(3, 1'b1);
    check("flood3_count", fl.free_count_o, 2);
    exp_q.push_back(5);
    exp_q.push_back(3);
    alloc_n(2);
    check("flood_drain_count", fl.free_count_o, 0);

    // Simultaneous alloc and free at count 10
    for (int unsigned i = 0; i < 10; i++) free_blk(i, 1'b0);
    check("fill10_count", fl.free_count_o, 10);
    exp_q.push_back(0);
    fl.alloc_req_i = 1'b1;
    free_blk(12, 1'b0);
    fl.alloc_req_i = 1'b0;
    check("simul_gnt",   fl.alloc_gnt_o, 1);
    check("simul_count", fl.free_count_o, 10);
    for (int unsigned i = 1; i < 10; i++) exp_q.push_back(i);
    exp_q.push_back(12);
    alloc_n(10);
    check("simul_drain_count", fl.free_count_o, 0);

    // Overflow on a full pool
    for (int unsigned i = 0; i < 16; i++) free_blk(i, 1'b0);
    check("full_count", fl.free_count_o, 16);
    check("full_err",   fl.err_o, 0);
    free_blk(2, 1'b0);
    check("ovf_err",   fl.err_o, 1);
    check("ovf_count", fl.free_count_o, 16);
    @(negedge clk);
    check("ovf_err_sticky", fl.err_o, 1);

    // Reset in the middle of a grant
    exp_q.push_back(0);
    fl.alloc_req_i = 1'b1;
    @(negedge clk);
    #1;
    rst = 1'b1;
    fl.alloc_req_i = 1'b0;
    #1;
    check("mid_rst_gnt",   fl.alloc_gnt_o, 0);
    check("mid_rst_idx",   fl.alloc_block_idx_o, 0);
    check("mid_rst_ready", fl.ready_o, 0);
    check("mid_rst_empty", fl.empty_o, 1);
    check("mid_rst_count", fl.free_count_o, 0);
    check("mid_rst_err",   fl.err_o, 0);
    @(negedge clk);
    rst = 1'b0;
    wait_ready(cyc);
    check("reinit_cycles", cyc, 16);
    check("reinit_count",  fl.free_count_o, 16);

    // Request during INIT flags an error and is not granted
    #1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    fl.alloc_req_i = 1'b1;
    @(negedge clk);
    fl.alloc_req_i = 1'b0;
    check("init_req_err",   fl.err_o, 1);
    check("init_req_ready", fl.ready_o, 0);
    check("init_req_gnt",   fl.alloc_gnt_o, 0);
    wait_ready(cyc);
    check("init_req_wait",  cyc, 15);
    check("init_req_count", fl.free_count_o, 16);

    @(negedge clk);
    check("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
